// File: rtl/bpuf_chal_sequencer.sv
// Challenge sequencer for a PUF: applies a challenge, waits for it to settle,
// takes SAMPLES response snapshots and reports a per-bit majority vote.
module bpuf_chal_sequencer #(
  parameter int CHAL_W  = 19,
  parameter int RESP_W  = 19,
  parameter int SETTLE  = 8,
  parameter int SAMPLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CHAL_W-1:0] req_chal,
  output logic              puf_enable,
  output logic [CHAL_W-1:0] puf_chal,
  input  logic [RESP_W-1:0] puf_resp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RESP_W-1:0] rsp_data,
  output logic [RESP_W-1:0] rsp_unstable,
  output logic              busy
);

  localparam int OW = $clog2(SAMPLES + 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);
  localparam logic [OW-1:0] HALF = OW'(SAMPLES / 2);
  localparam logic [OW-1:0] ALL  = OW'(SAMPLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_VOTE,
    S_DONE
  } state_t;

  state_t                      state_q;
  logic [7:0]                  cnt_q;
  logic [RESP_W-1:0][OW-1:0]   ones_q;
  logic                        puf_enable_q;
  logic [CHAL_W-1:0]           puf_chal_q;
  logic                        rsp_valid_q;
  logic [RESP_W-1:0]           rsp_data_q;
  logic [RESP_W-1:0]           rsp_unstable_q;

  logic [RESP_W-1:0][OW-1:0]   ones_d;
  logic [RESP_W-1:0]           vote_d;
  logic [RESP_W-1:0]           unstable_d;

  // Per-bit ones counters and the vote derived from their settled values.
  for (genvar gi = 0; gi < RESP_W; gi++) begin : g_bit
    assign ones_d[gi]     = ones_q[gi] + OW'(puf_resp[gi]);
    assign vote_d[gi]     = (ones_q[gi] > HALF);
    assign unstable_d[gi] = (ones_q[gi] != '0) && (ones_q[gi] != ALL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      ones_q         <= '0;
      puf_enable_q   <= 1'b0;
      puf_chal_q     <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_unstable_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            puf_chal_q   <= req_chal;
            puf_enable_q <= 1'b1;
            cnt_q        <= '0;
            ones_q       <= '0;
            state_q      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_SAMPLE: begin
          ones_q <= ones_d;
          if (cnt_q == SAMPLE_LAST) begin
            cnt_q        <= '0;
            puf_enable_q <= 1'b0;
            state_q      <= S_VOTE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_VOTE: begin
          rsp_data_q     <= vote_d;
          rsp_unstable_q <= unstable_d;
          rsp_valid_q    <= 1'b1;
          state_q        <= S_DONE;
        end
        S_DONE: begin
          // Response registers keep their value after the handshake.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign puf_enable   = puf_enable_q;
  assign puf_chal     = puf_chal_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_unstable = rsp_unstable_q;

endmodule

// File: tb/tb_bpuf_chal_sequencer.sv
// Randomized bench for bpuf_chal_sequencer: a sample-list majority model
// predicts each response; a second instance covers SAMPLES=1, SETTLE=1.
module tb_bpuf_chal_sequencer;

  localparam int SET = 8;
  localparam int SMP = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [18:0] req_chal = '0;
  logic        puf_enable;
  logic [18:0] puf_chal;
  logic [18:0] puf_resp = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [18:0] rsp_data;
  logic [18:0] rsp_unstable;
  logic        busy;

  logic        req_valid_b = 1'b0;
  logic        req_ready_b;
  logic [18:0] req_chal_b = '0;
  logic        puf_enable_b;
  logic [18:0] puf_chal_b;
  logic [18:0] puf_resp_b = '0;
  logic        rsp_valid_b;
  logic        rsp_ready_b = 1'b0;
  logic [18:0] rsp_data_b;
  logic [18:0] rsp_unstable_b;
  logic        busy_b;

  int errors = 0;
  int checks = 0;
  logic [18:0] samp_q[$];

  always #5 clk = ~clk;

  bpuf_chal_sequencer #(.CHAL_W(19), .RESP_W(19), .SETTLE(SET), .SAMPLES(SMP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_chal(req_chal), .puf_enable(puf_enable), .puf_chal(puf_chal),
    .puf_resp(puf_resp), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_unstable(rsp_unstable), .busy(busy)
  );

  bpuf_chal_sequencer #(.CHAL_W(19), .RESP_W(19), .SETTLE(1), .SAMPLES(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_chal(req_chal_b), .puf_enable(puf_enable_b), .puf_chal(puf_chal_b),
    .puf_resp(puf_resp_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
    .rsp_data(rsp_data_b), .rsp_unstable(rsp_unstable_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Majority and disagreement per bit over the captured sample list.
  function automatic void model(output logic [18:0] d, output logic [18:0] u);
    d = '0;
    u = '0;
    for (int b = 0; b < 19; b++) begin
      int ones;
      ones = 0;
      foreach (samp_q[k]) ones += int'(samp_q[k][b]);
      d[b] = (2 * ones > samp_q.size());
      u[b] = (ones != 0) && (ones != samp_q.size());
    end
  endfunction

  task automatic run_txn(input string name, input logic [18:0] chal, input bit fixed,
                         input logic [18:0] f0, input logic [18:0] f1, input logic [18:0] f2,
                         input int bp, input bit poke);
    logic [18:0] r;
    logic [18:0] exp_d;
    logic [18:0] exp_u;
    int err0;
    err0 = errors;
    samp_q.delete();
    req_chal  = chal;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_chal  = 19'($urandom);
    checks++; if (puf_chal !== chal) begin errors++;
      $display("FAIL %s accept_chal: got %h want %h", name, puf_chal, chal); end
    checks++; if (puf_enable !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin errors++;
      $display("FAIL %s accept_flags: en=%b busy=%b ready=%b want 1 1 0", name, puf_enable, busy, req_ready); end
    for (int e = 1; e <= SET + SMP; e++) begin
      if (!fixed || e <= SET) r = fixed ? f0 : 19'($urandom);
      else r = (e == SET + 1) ? f0 : ((e == SET + 2) ? f1 : f2);
      puf_resp = r;
      if (poke && e == SET + 2) begin
        req_valid = 1'b1;
        req_chal  = 19'h00AAA;
      end else begin
        req_valid = 1'b0;
      end
      tick();
      if (e > SET) samp_q.push_back(r);
      checks++; if (puf_enable !== (e < SET + SMP) || rsp_valid !== 1'b0 || puf_chal !== chal) begin errors++;
        $display("FAIL %s run_e%0d: en=%b vld=%b chal=%h want en=%b vld=0 chal=%h",
                 name, e, puf_enable, rsp_valid, puf_chal, (e < SET + SMP), chal); end
    end
    req_valid = 1'b0;
    puf_resp  = 19'($urandom);
    tick();
    model(exp_d, exp_u);
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_unstable !== exp_u) begin errors++;
      $display("FAIL %s response: vld=%b data=%h unst=%h want 1 %h %h",
               name, rsp_valid, rsp_data, rsp_unstable, exp_d, exp_u); end
    for (int c = 0; c < bp; c++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_chal  = 19'($urandom);
      puf_resp  = 19'($urandom);
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_unstable !== exp_u ||
                    req_ready !== 1'b0 || puf_chal !== chal) begin errors++;
        $display("FAIL %s hold_c%0d: vld=%b data=%h unst=%h rdy=%b chal=%h want 1 %h %h 0 %h",
                 name, c, rsp_valid, rsp_data, rsp_unstable, req_ready, puf_chal, exp_d, exp_u, chal); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 ||
                  rsp_data !== exp_d || rsp_unstable !== exp_u || puf_chal !== chal) begin errors++;
      $display("FAIL %s handshake: vld=%b rdy=%b busy=%b data=%h unst=%h chal=%h",
               name, rsp_valid, req_ready, busy, rsp_data, rsp_unstable, puf_chal); end
    $display("txn %s chal=%h data=%h unstable=%h bp=%0d %s", name, chal, exp_d, exp_u, bp,
             (errors == err0) ? "ok" : "bad");
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (puf_enable !== 1'b0 || puf_chal !== 19'h0 || rsp_valid !== 1'b0 ||
                  rsp_data !== 19'h0 || rsp_unstable !== 19'h0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_state: en=%b chal=%h vld=%b data=%h unst=%h busy=%b want all 0",
               puf_enable, puf_chal, rsp_valid, rsp_data, rsp_unstable, busy); end
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready); end
    $display("txn reset_state done");
  endtask

  task automatic test_stable();
    run_txn("stable", 19'h12345, 1'b1, 19'h5A5A5, 19'h5A5A5, 19'h5A5A5, 0, 1'b0);
  endtask

  task automatic test_majority();
    run_txn("majority", 19'($urandom), 1'b1, 19'h7FFFF, 19'h00001, 19'h7FFFF, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      run_txn("random", 19'($urandom), 1'b0, '0, '0, '0, $urandom_range(0, 3), 1'b0);
  endtask

  task automatic test_backpressure();
    run_txn("backpressure", 19'($urandom), 1'b0, '0, '0, '0, 5, 1'b0);
  endtask

  task automatic test_busy_request();
    run_txn("busy_request", 19'h3C3C3, 1'b0, '0, '0, '0, 1, 1'b1);
    for (int c = 0; c < 15; c++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || puf_chal !== 19'h3C3C3) begin errors++;
        $display("FAIL busy_request_extra_c%0d: vld=%b rdy=%b chal=%h want 0 1 3c3c3",
                 c, rsp_valid, req_ready, puf_chal); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_txn("back_to_back", 19'($urandom), 1'b0, '0, '0, '0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_settle();
    logic [18:0] c2;
    req_chal  = 19'($urandom);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (puf_enable !== 1'b0 || puf_chal !== 19'h0 || rsp_valid !== 1'b0 ||
                  rsp_data !== 19'h0 || rsp_unstable !== 19'h0 || busy !== 1'b0) begin errors++;
      $display("FAIL reset_async: en=%b chal=%h vld=%b data=%h unst=%h busy=%b want all 0",
               puf_enable, puf_chal, rsp_valid, rsp_data, rsp_unstable, busy); end
    tick();
    reset     = 1'b0;
    c2        = 19'($urandom);
    req_chal  = c2;
    req_valid = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready_after: got %b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    checks++; if (puf_chal !== c2 || puf_enable !== 1'b1) begin errors++;
      $display("FAIL reset_first_accept: chal=%h en=%b want %h 1", puf_chal, puf_enable, c2); end
    tick();
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
        $display("FAIL reset_abort_c%0d: vld=%b busy=%b want 0 0", c, rsp_valid, busy); end
    end
    rsp_ready = 1'b0;
    $display("txn reset_mid_settle chal=%h aborted", c2);
  endtask

  task automatic test_single_sample();
    logic [18:0] r;
    for (int i = 0; i < 4; i++) begin
      r = (i == 0) ? 19'h00F0F : 19'($urandom);
      req_chal_b  = 19'($urandom);
      req_valid_b = 1'b1;
      tick();
      req_valid_b = 1'b0;
      puf_resp_b  = ~r;
      tick();
      puf_resp_b  = r;
      checks++; if (puf_enable_b !== 1'b1 || rsp_valid_b !== 1'b0) begin errors++;
        $display("FAIL single_settle: en=%b vld=%b want 1 0", puf_enable_b, rsp_valid_b); end
      tick();
      puf_resp_b = 19'($urandom);
      checks++; if (puf_enable_b !== 1'b0 || rsp_valid_b !== 1'b0) begin errors++;
        $display("FAIL single_capture: en=%b vld=%b want 0 0", puf_enable_b, rsp_valid_b); end
      tick();
      checks++; if (rsp_valid_b !== 1'b1 || rsp_data_b !== r || rsp_unstable_b !== 19'h0) begin errors++;
        $display("FAIL single_response: vld=%b data=%h unst=%h want 1 %h 0",
                 rsp_valid_b, rsp_data_b, rsp_unstable_b, r); end
      rsp_ready_b = 1'b1;
      tick();
      rsp_ready_b = 1'b0;
      checks++; if (rsp_valid_b !== 1'b0 || req_ready_b !== 1'b1 || rsp_data_b !== r) begin errors++;
        $display("FAIL single_handshake: vld=%b rdy=%b data=%h want 0 1 %h",
                 rsp_valid_b, req_ready_b, rsp_data_b, r); end
      $display("txn single_sample resp=%h", r);
    end
  endtask

  initial begin
    test_reset();
    test_stable();
    test_majority();
    test_random();
    test_backpressure();
    test_busy_request();
    test_back_to_back();
    test_reset_mid_settle();
    test_single_sample();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bpuf_chal_sequencer.md
BPUF_CHAL_SEQUENCER -- requirements
Module: bpuf_chal_sequencer

Interface
REQ-001 SHALL have parameter CHAL_W, default 19, challenge width.
REQ-002 SHALL have parameter RESP_W, default 19, response width.
REQ-003 SHALL have parameter SETTLE, default 8, settle cycles after the challenge is applied; legal range 1..255.
REQ-004 SHALL have parameter SAMPLES, default 3, response samples per challenge; legal values are odd, 1..15.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 req_valid  input  1  challenge request valid.
REQ-008 req_ready  output  1  sequencer can accept a challenge.
REQ-009 req_chal  input  CHAL_W  challenge to apply.
REQ-010 puf_enable  output  1  enable to the downstream PUF.
REQ-011 puf_chal  output  CHAL_W  registered challenge driven to the PUF.
REQ-012 puf_resp  input  RESP_W  raw PUF response.
REQ-013 rsp_valid  output  1  voted response valid.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_data  output  RESP_W  per-bit majority-voted response.
REQ-016 rsp_unstable  output  RESP_W  per-bit flag, set when samples disagreed.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, SETTLE, SAMPLE, VOTE, DONE.
REQ-019 IDLE: req_ready=1; a request is accepted on edge T when req_valid&req_ready; on T, load puf_chal<=req_chal, set puf_enable=1, clear the cycle counter and all per-bit ones-counters, then go to SETTLE.
REQ-020 SETTLE: count SETTLE cycles, then go to SAMPLE; PUF samples are not captured in this state.
REQ-021 SAMPLE: capture puf_resp on edges T+SETTLE+1 through T+SETTLE+SAMPLES; each capture adds each bit into its own ones-counter of width clog2(SAMPLES+1); after the last capture, clear puf_enable and go to VOTE.
REQ-022 VOTE (one cycle): set rsp_data[i] = (ones[i] > SAMPLES/2) and rsp_unstable[i] = (ones[i]!=0 && ones[i]!=SAMPLES), then go to DONE; rsp_valid is first high after edge T+SETTLE+SAMPLES+1 (edge T+12 with default parameters).
REQ-023 DONE: rsp_valid=1; rsp_data and rsp_unstable SHALL hold stable until rsp_valid&rsp_ready, and on that edge go to IDLE with rsp_valid=0.
REQ-024 req_ready SHALL be 0 outside IDLE; a req_valid seen outside IDLE is ignored, not queued.
REQ-025 Back-to-back transactions: the earliest next accept is the edge after the response handshake, which gives at least one IDLE cycle.
REQ-026 puf_chal SHALL hold its last value between transactions; rsp_data and rsp_unstable SHALL hold their last values after the handshake.
REQ-027 With SAMPLES=1, rsp_data SHALL equal the single sample and rsp_unstable SHALL be all zero.
REQ-028 A change in req_chal after the accept edge SHALL NOT affect puf_chal for that transaction.

Reset
REQ-029 On reset assertion, regardless of clk: state=IDLE, puf_enable=0, puf_chal=0, rsp_valid=0, rsp_data=0, rsp_unstable=0, busy=0, all counters=0.
REQ-030 Reset mid-transaction SHALL abort the transaction with no response produced.
REQ-031 After reset deasserts, req_ready=1 from the first cycle.

Verification
REQ-032 Stable response: chal=0x12345, puf_resp held at 0x5A5A5 -> puf_enable high from T to T+11, rsp_valid after edge T+12, rsp_data=0x5A5A5, rsp_unstable=0.
REQ-033 Majority: samples 0x7FFFF, 0x00001, 0x7FFFF -> rsp_data=0x7FFFF, rsp_unstable=0x7FFFE.
REQ-034 Backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_valid, rsp_data and rsp_unstable stable throughout; req_ready=0; IDLE entered on the edge after rsp_ready rises.
REQ-035 Busy request: req_valid with chal=0x00AAA pulsed during SAMPLE -> not accepted; puf_chal unchanged; exactly one response produced.
REQ-036 Reset mid-SETTLE (cycle T+4) -> all outputs zero immediately; no rsp_valid; a new request is accepted on the first edge after reset deasserts.
REQ-037 SAMPLES=1, SETTLE=1: puf_resp=0x00F0F -> rsp_valid after edge T+3, rsp_data=0x00F0F, rsp_unstable=0.
